// File: rtl/ucode_loader_pkg.sv
// Shared byte constants and FSM state encoding for the uCode serial loader.
package ucode_loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_ADDR,
    S_CNT,
    S_HI,
    S_LO,
    S_CHK,
    S_RUN,
    S_TX
  } state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] ESC_BYTE   = 8'h1B;
  localparam logic [7:0] NAK_BYTE   = 8'h15;
  localparam logic [7:0] OK_BYTE    = 8'h4F;
  localparam logic [7:0] FAIL_BYTE  = 8'h46;
  localparam logic [7:0] ABORT_BYTE = 8'h41;

  // Frame is valid when the running sum plus the checksum byte wraps to zero.
  function automatic logic sum_ok(input logic [7:0] sum, input logic [7:0] chk);
    logic [7:0] total;
    total = sum + chk;
    return total == 8'h00;
  endfunction

endpackage

// File: rtl/ucode_loader_rx_timeout.sv
// Inter-byte idle counter: expire pulses on the TIMEOUT-th consecutive enabled idle cycle.
module rx_timeout #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // count holds the number of idle cycles already elapsed before this one
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || clear || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ucode_loader.sv
// Serial program loader: framed bytes -> uCode memory writes, CPU run request, result byte.
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter int unsigned DATA_SZ = 16,
  parameter int unsigned ADDR_SZ = 8,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_wr,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_run,
  input  logic               i_running,
  input  logic               i_status
);

  state_t     state, state_d;
  logic [7:0] base_q, cnt_q, idx_q, hi_q, sum_q;
  logic [7:0] idx_inc;
  logic       run_first_q;
  logic       tmo_en, tmo_exp;
  logic       tx_load;
  logic [7:0] tx_byte;

  assign tmo_en  = (state == S_ADDR) || (state == S_CNT) || (state == S_HI) ||
                   (state == S_LO)   || (state == S_CHK);
  assign idx_inc = idx_q + 8'd1;

  rx_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (i_rx_valid),
    .enable(tmo_en),
    .expire(tmo_exp)
  );

  always_comb begin
    state_d = state;
    tx_load = 1'b0;
    tx_byte = 8'h00;
    if (tmo_exp) begin
      state_d = S_TX;
      tx_load = 1'b1;
      tx_byte = NAK_BYTE;
    end else begin
      unique case (state)
        S_SYNC: if (i_rx_valid && i_rx_data == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: if (i_rx_valid) state_d = S_CNT;
        S_CNT:  if (i_rx_valid) state_d = S_HI;
        S_HI:   if (i_rx_valid) state_d = S_LO;
        // 8-bit wrap makes CNT=0 terminate after 256 words
        S_LO:   if (i_rx_valid) state_d = (idx_inc == cnt_q) ? S_CHK : S_HI;
        S_CHK: begin
          if (i_rx_valid) begin
            if (sum_ok(sum_q, i_rx_data)) begin
              state_d = S_RUN;
            end else begin
              state_d = S_TX;
              tx_load = 1'b1;
              tx_byte = NAK_BYTE;
            end
          end
        end
        S_RUN: begin
          // CPU completion takes priority over a simultaneous escape byte
          if (!run_first_q && !i_running) begin
            state_d = S_TX;
            tx_load = 1'b1;
            tx_byte = i_status ? OK_BYTE : FAIL_BYTE;
          end else if (i_rx_valid && i_rx_data == ESC_BYTE) begin
            state_d = S_TX;
            tx_load = 1'b1;
            tx_byte = ABORT_BYTE;
          end
        end
        S_TX:   if (o_tx_valid && i_tx_ready) state_d = S_SYNC;
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_SYNC;
      o_wr        <= 1'b0;
      o_waddr     <= '0;
      o_wdata     <= '0;
      o_run       <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
      run_first_q <= 1'b1;
    end else begin
      state       <= state_d;
      o_run       <= (state_d == S_RUN);
      o_tx_valid  <= (state_d == S_TX);
      run_first_q <= (state != S_RUN);
      o_wr        <= 1'b0;
      if (tx_load) o_tx_data <= tx_byte;
      if (i_rx_valid) begin
        unique case (state)
          S_ADDR: begin
            base_q <= i_rx_data;
            idx_q  <= '0;
            sum_q  <= i_rx_data;
          end
          S_CNT: begin
            cnt_q <= i_rx_data;
            sum_q <= sum_q + i_rx_data;
          end
          S_HI: begin
            hi_q  <= i_rx_data;
            sum_q <= sum_q + i_rx_data;
          end
          S_LO: begin
            o_wr    <= 1'b1;
            o_waddr <= ADDR_SZ'(base_q + idx_q);
            o_wdata <= DATA_SZ'({hi_q, i_rx_data});
            idx_q   <= idx_inc;
            sum_q   <= sum_q + i_rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: vector table of frames plus hand-written corner sequences.
module tb_ucode_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        wr;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        run;
  logic        running = 1'b0;
  logic        status = 1'b0;

  always #5 clk = ~clk;

  ucode_loader #(
    .DATA_SZ(16),
    .ADDR_SZ(8),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rx_data (rx_data),
    .i_rx_valid(rx_valid),
    .o_tx_data (tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_wr      (wr),
    .o_waddr   (waddr),
    .o_wdata   (wdata),
    .o_run     (run),
    .i_running (running),
    .i_status  (status)
  );

  typedef struct {
    logic [7:0] a;
    logic [15:0] d;
  } wr_t;

  // mode: 0 = CPU completes, 1 = escape abort, 2 = escape and completion together
  typedef struct {
    logic [7:0]       addr;
    logic [7:0]       cnt;
    logic [3:0][15:0] w;
    bit               explicit_chk;
    logic [7:0]       chk;
    bit               runs;
    int               mode;
    bit               status;
    bit               stray;
    logic [7:0]       exp_tx;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] tq[$];
  int errors = 0;
  int checks = 0;
  int nwr = 0;
  logic prev_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare every write and every completed TX handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (wr) begin
        nwr++;
        chk("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", waddr, wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("waddr", {24'd0, waddr}, {24'd0, e.a});
          chk("wdata", {16'd0, wdata}, {16'd0, e.d});
        end
      end
      prev_wr = wr;
      if (tx_valid && tx_ready) begin
        if (tq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else begin
          chk("tx_data", {24'd0, tx_data}, {24'd0, tq.pop_front()});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_tx_done();
    for (int i = 0; i < 100 && tx_valid; i++) cyc();
    chk("tx_done", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic cpu_finish(input bit st, input logic [7:0] exp);
    tq.push_back(exp);
    status  = st;
    running = 1'b0;
    cyc();
    chk("run_fall", {31'd0, run}, 32'd0);
    chk("tx_rise", {31'd0, tx_valid}, 32'd1);
    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp});
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] s, c;
    s = v.addr + v.cnt;
    send_byte(8'hA5);
    send_byte(v.addr);
    send_byte(v.cnt);
    for (int i = 0; i < int'(v.cnt); i++) begin
      wr_t e;
      e.a = v.addr + 8'(i);
      e.d = v.w[i];
      wq.push_back(e);
      send_byte(v.w[i][15:8]);
      send_byte(v.w[i][7:0]);
      s = s + v.w[i][15:8] + v.w[i][7:0];
    end
    c = v.explicit_chk ? v.chk : 8'h00 - s;
    if (!v.runs) begin
      tq.push_back(v.exp_tx);
      send_byte(c);
      chk("no_run", {31'd0, run}, 32'd0);
      chk("nak_valid", {31'd0, tx_valid}, 32'd1);
      chk("nak_byte", {24'd0, tx_data}, {24'd0, v.exp_tx});
    end else begin
      send_byte(c);
      chk("run_rise", {31'd0, run}, 32'd1);
      running = 1'b1;
      repeat (3) cyc();
      if (v.stray) begin
        send_byte(8'h33);
        chk("run_hold", {31'd0, run}, 32'd1);
      end
      if (v.mode == 0) begin
        cpu_finish(v.status, v.exp_tx);
      end else begin
        tq.push_back(v.exp_tx);
        if (v.mode == 2) begin
          status  = 1'b1;
          running = 1'b0;
        end
        send_byte(8'h1B);
        chk("run_fall", {31'd0, run}, 32'd0);
        chk("tx_rise", {31'd0, tx_valid}, 32'd1);
        chk("tx_byte", {24'd0, tx_data}, {24'd0, v.exp_tx});
        running = 1'b0;
      end
    end
    wait_tx_done();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_wr"}, {31'd0, wr}, 32'd0);
    chk({nm, "_waddr"}, {24'd0, waddr}, 32'd0);
    chk({nm, "_wdata"}, {16'd0, wdata}, 32'd0);
    chk({nm, "_run"}, {31'd0, run}, 32'd0);
    chk({nm, "_txv"}, {31'd0, tx_valid}, 32'd0);
    chk({nm, "_txd"}, {24'd0, tx_data}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{addr:8'h80, cnt:8'd2, w:{16'h0, 16'h0, 16'h000F, 16'h000D}, explicit_chk:1'b1,
                chk:8'h62, runs:1'b1, mode:0, status:1'b1, stray:1'b0, exp_tx:8'h4F};
    vecs[1] = '{addr:8'h10, cnt:8'd1, w:{16'h0, 16'h0, 16'h0, 16'h1234}, explicit_chk:1'b1,
                chk:8'h00, runs:1'b0, mode:0, status:1'b0, stray:1'b0, exp_tx:8'h15};
    vecs[2] = '{addr:8'h3C, cnt:8'd3, w:{16'h0, 16'h0001, 16'h5555, 16'hAAAA}, explicit_chk:1'b0,
                chk:8'h00, runs:1'b1, mode:0, status:1'b0, stray:1'b1, exp_tx:8'h46};
    vecs[3] = '{addr:8'hFE, cnt:8'd4, w:{16'h4444, 16'h3333, 16'h2222, 16'h1111}, explicit_chk:1'b0,
                chk:8'h00, runs:1'b1, mode:0, status:1'b1, stray:1'b0, exp_tx:8'h4F};
    vecs[4] = '{addr:8'h00, cnt:8'd1, w:{16'h0, 16'h0, 16'h0, 16'hFFFF}, explicit_chk:1'b0,
                chk:8'h00, runs:1'b1, mode:1, status:1'b1, stray:1'b1, exp_tx:8'h41};
    vecs[5] = '{addr:8'h55, cnt:8'd2, w:{16'h0, 16'h0, 16'hBEEF, 16'hCAFE}, explicit_chk:1'b0,
                chk:8'h00, runs:1'b1, mode:2, status:1'b1, stray:1'b0, exp_tx:8'h4F};

    repeat (3) cyc();
    chk_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // CNT=0 means 256 words, and the address wraps past FF
    begin
      logic [7:0] s;
      int n0;
      n0 = nwr;
      s  = 8'hFF;
      send_byte(8'hA5);
      send_byte(8'hFF);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
        wr_t e;
        e.a = 8'hFF + 8'(i);
        e.d = {8'(i), 8'(8'd255 - 8'(i))};
        wq.push_back(e);
        send_byte(e.d[15:8]);
        send_byte(e.d[7:0]);
        s = s + e.d[15:8] + e.d[7:0];
      end
      send_byte(8'h00 - s);
      chk("wrap_run_rise", {31'd0, run}, 32'd1);
      running = 1'b1;
      cyc();
      cpu_finish(1'b1, 8'h4F);
      wait_tx_done();
      chk("wrap_wr_count", nwr - n0, 32'd256);
    end

    // Timeout: NAK appears exactly TMO idle cycles after the last byte
    send_byte(8'hA5);
    send_byte(8'h20);
    for (int k = 1; k < TMO; k++) cyc();
    chk("tmo_early", {31'd0, tx_valid}, 32'd0);
    tq.push_back(8'h15);
    cyc();
    chk("tmo_fire", {31'd0, tx_valid}, 32'd1);
    chk("tmo_byte", {24'd0, tx_data}, 32'h15);
    wait_tx_done();
    run_vec(vecs[0]);

    // TX backpressure: byte held stable while ready is low; bytes during TX are dropped
    tx_ready = 1'b0;
    tq.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    begin
      wr_t e;
      e.a = 8'h10;
      e.d = 16'h1234;
      wq.push_back(e);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h00);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", {31'd0, tx_valid}, 32'd1);
      chk("bp_data", {24'd0, tx_data}, 32'h15);
      if (k == 4) send_byte(8'hA5);
      else cyc();
    end
    tx_ready = 1'b1;
    wait_tx_done();
    run_vec(vecs[2]);

    // Reset mid-frame (after a hi byte)
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h12);
    rst = 1'b1;
    cyc();
    chk_reset_outputs("rst_frame");
    rst = 1'b0;
    cyc();
    run_vec(vecs[3]);

    // Reset mid-run: o_run drops, no result byte
    send_byte(8'hA5);
    send_byte(8'h40);
    send_byte(8'h01);
    begin
      wr_t e;
      e.a = 8'h40;
      e.d = 16'h0102;
      wq.push_back(e);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00 - 8'h44);
    chk("rst_run_rise", {31'd0, run}, 32'd1);
    running = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk_reset_outputs("rst_run");
    rst = 1'b0;
    running = 1'b0;
    repeat (5) cyc();
    chk("rst_run_no_tx", {31'd0, tx_valid}, 32'd0);
    run_vec(vecs[5]);

    repeat (3) cyc();
    chk("wq_empty", wq.size(), 32'd0);
    chk("tq_empty", tq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion before time limit");
    $fatal(1, "watchdog");
  end

endmodule
